// File: rtl/rtype_instr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// rtype_instr_encoder_pkg
//   Shared RV32I R-type constants, ALU op enum and the combinational encoder.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rtype_instr_encoder_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
  localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;
  localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_word_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= ALU_AND);
  endfunction

  // Illegal ops fall through to an ADD-shaped word; callers gate them with op_is_legal.
  function automatic logic [31:0] encode_rtype(
    input logic [3:0] op,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    rtype_word_t w;
    w.opcode = OPCODE_RTYPE;
    w.rd     = rd;
    w.rs1    = rs1;
    w.rs2    = rs2;
    w.funct7 = FUNCT7_BASE;
    w.funct3 = FUNCT3_ADD_SUB;
    case (alu_op_e'(op))
      ALU_ADD:  w.funct3 = FUNCT3_ADD_SUB;
      ALU_SUB:  begin
        w.funct3 = FUNCT3_ADD_SUB;
        w.funct7 = FUNCT7_ALT;
      end
      ALU_SLL:  w.funct3 = FUNCT3_SLL;
      ALU_SLT:  w.funct3 = FUNCT3_SLT;
      ALU_SLTU: w.funct3 = FUNCT3_SLTU;
      ALU_XOR:  w.funct3 = FUNCT3_XOR;
      ALU_SRL:  w.funct3 = FUNCT3_SRL_SRA;
      ALU_SRA:  begin
        w.funct3 = FUNCT3_SRL_SRA;
        w.funct7 = FUNCT7_ALT;
      end
      ALU_OR:   w.funct3 = FUNCT3_OR;
      ALU_AND:  w.funct3 = FUNCT3_AND;
      default:  w.funct3 = FUNCT3_ADD_SUB;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtype_instr_encoder_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock count-based FIFO; head word is presented combinationally.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w:0] c_depth = DEPTH[c_ptr_w:0];

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  logic w_do_wr;
  logic w_do_rd;

  assign full    = (r_count == c_depth);
  assign empty   = (r_count == '0);
  assign w_do_wr = wr_en & ~full;
  assign w_do_rd = rd_en & ~empty;
  assign rd_data = r_mem[r_rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/rtype_instr_encoder.sv
// ---------------------------------------------------------------------------
// rtype_instr_encoder
//   Encodes ALU requests into RV32I R-type words and buffers them in a FIFO.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rtype_instr_encoder
  import rtype_instr_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  output logic [CNT_W-1:0] enc_count
);

  logic        w_legal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_word;

  logic             r_err;
  logic [CNT_W-1:0] r_enc_count;

  assign w_legal  = op_is_legal(in_op);
  assign w_word   = encode_rtype(in_op, in_rd, in_rs1, in_rs2);
  // Ready depends only on registered occupancy, so out_ready never reaches in_ready.
  assign in_ready = ~rst & ~w_full;
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & w_legal;
  assign w_pop    = out_valid & out_ready;

  assign out_valid = ~w_empty;
  assign err       = r_err;
  assign enc_count = r_enc_count;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (w_word),
    .rd_en   (w_pop),
    .rd_data (out_instr),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err       <= 1'b0;
      r_enc_count <= '0;
    end else begin
      r_err <= w_accept & ~w_legal;
      if (w_push) r_enc_count <= r_enc_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rtype_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_rtype_instr_encoder
//   Directed + random stimulus against a queue-based model of the encoder.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rtype_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int F3_TAB [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_op = '0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic             err;
  logic [CNT_W-1:0] enc_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [31:0]      m_q[$];
  logic             m_err;
  logic [CNT_W-1:0] m_cnt;

  rtype_instr_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .err       (err),
    .enc_count (enc_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(int op, int rd, int rs1, int rs2);
    int f7;
    f7 = (op == 1 || op == 7) ? 32 : 0;
    return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (F3_TAB[op] << 12) | (rd << 7) | 'h33);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is just a queue of encoded words.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_err <= 1'b0;
      m_cnt <= '0;
    end else begin
      bit acc;
      acc = in_valid && (m_q.size() < DEPTH);
      m_err <= acc && (in_op > 9);
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      if (acc && in_op <= 9) begin
        m_q.push_back(ref_word(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2)));
        m_cnt <= m_cnt + CNT_W'(1);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, (!rst && m_q.size() < DEPTH));
      chk("out_valid", out_valid, (m_q.size() != 0));
      if (m_q.size() != 0) chk("out_instr", out_instr, m_q[0]);
      chk("err", err, m_err);
      chk("enc_count", enc_count, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int op, int rd, int rs1, int rs2);
    int guard;
    bit ok;
    guard = 0;
    in_valid = 1'b1;
    in_op = op[3:0];
    in_rd = rd[4:0];
    in_rs1 = rs1[4:0];
    in_rs2 = rs2[4:0];
    do begin
      ok = (m_q.size() < DEPTH);
      step();
      guard++;
    end while (!ok && guard < 500);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no accept expected accept within 500 cycles");
    end
    in_valid = 1'b0;
  endtask

  initial begin
    chk("model_add", ref_word(0, 1, 2, 3), 32'h003100B3);
    chk("model_sub", ref_word(1, 1, 3, 2), 32'h402180B3);
    chk("model_sra", ref_word(7, 1, 3, 2), 32'h4021D0B3);
    chk("model_and", ref_word(9, 31, 31, 31), 32'h01FFFFB3);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Single ADD with the consumer always ready
    out_ready = 1'b1;
    send(0, 1, 2, 3);
    chk("add_word", out_instr, 32'h003100B3);
    chk("add_valid", out_valid, 1'b1);
    chk("add_count", enc_count, 16'd1);
    step();

    // SUB then SRA, ordering across the FIFO
    out_ready = 1'b0;
    send(1, 1, 3, 2);
    send(7, 1, 3, 2);
    chk("sub_word", out_instr, 32'h402180B3);
    out_ready = 1'b1;
    step();
    chk("sra_word", out_instr, 32'h4021D0B3);
    step();

    // Illegal op: err pulse only, count unchanged
    send(12, 4, 5, 6);
    chk("ill_err", err, 1'b1);
    chk("ill_valid", out_valid, 1'b0);
    chk("ill_count", enc_count, 16'd3);
    step();
    chk("ill_err_end", err, 1'b0);
    send(0, 7, 8, 9);
    step();

    // Back-pressure: six requests against a stalled consumer
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(i + 2, i + 1, i + 10, i + 20);
          if (i == 3) chk("full_ready", in_ready, 1'b0);
        end
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (8) step();

    // Asynchronous reset with two words buffered
    out_ready = 1'b0;
    send(5, 2, 3, 4);
    send(6, 5, 6, 7);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", enc_count, 16'd0);
    chk("rst_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1'b1);
    step();

    // Streaming push+pop at occupancy 1
    send(8, 1, 1, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_op = 4'($urandom_range(0, 9));
      in_rd = 5'($urandom);
      in_rs1 = 5'($urandom);
      in_rs2 = 5'($urandom);
      step();
      chk("pp_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Random traffic with varying consumer pressure
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      in_rd = 5'($urandom);
      in_rs1 = 5'($urandom);
      in_rs2 = 5'($urandom);
      if (i < 1000) out_ready = ($urandom_range(0, 3) != 0);
      else if (i < 2000) out_ready = ($urandom_range(0, 3) == 0);
      else out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
